// File: rtl/dds_phase_meter_pkg.sv
// -----------------------------------------------------------------------------
// dds_phase_meter_pkg
// Shared definitions for the DDS generator / phase meter pair:
//   - default tuning-word width (DDS_M), ramp sample width (DDS_W) and
//     window exponent (METER_G)
//   - phase meter FSM state encoding
//   - mod_dist(): shortest distance between two values on a 2^width circle,
//     used to compare consecutive frequency estimates across wrap-around.
// No ports (package).
// -----------------------------------------------------------------------------
package dds_phase_meter_pkg;

    localparam int unsigned DDS_M   = 24;
    localparam int unsigned DDS_W   = 16;
    localparam int unsigned METER_G = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_DONE  = 2'd2
    } meter_state_t;

    // Smaller of (a-b) and (b-a), both taken modulo 2^width.
    function automatic logic [63:0] mod_dist(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input int unsigned width);
        logic [63:0] mask;
        logic [63:0] fwd;
        logic [63:0] bwd;
        if (width >= 32'd64) begin
            mask = {64{1'b1}};
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        fwd = (a - b) & mask;
        bwd = (b - a) & mask;
        return (fwd < bwd) ? fwd : bwd;
    endfunction

endpackage

// File: rtl/dds_phase_meter_diff.sv
// -----------------------------------------------------------------------------
// dds_phase_diff
// Keeps the previously accepted ramp sample and produces the unsigned modular
// increment to the current one. The first sample after reset only primes the
// stored value; every later sample yields a valid delta.
// Ports:
//   clk          in  1  system clock, rising edge
//   rst_ac_n     in  1  asynchronous active-low reset
//   sample       in  1  current ramp_wave is accepted this cycle
//   ramp_wave    in  W  ramp sample (treated as unsigned)
//   delta        out W  (ramp_wave - prev) mod 2^W
//   delta_valid  out 1  delta is meaningful and accepted this cycle
// -----------------------------------------------------------------------------
module dds_phase_diff
    import dds_phase_meter_pkg::*;
#(
    parameter int unsigned W = DDS_W
) (
    input  logic         clk,
    input  logic         rst_ac_n,
    input  logic         sample,
    input  logic [W-1:0] ramp_wave,
    output logic [W-1:0] delta,
    output logic         delta_valid
);

    logic [W-1:0] prev_r;
    logic         primed_r;

    // Previous-sample register; survives window boundaries so no sample is lost.
    always_ff @(posedge clk or negedge rst_ac_n) begin
        if (!rst_ac_n) begin
            prev_r   <= {W{1'b0}};
            primed_r <= 1'b0;
        end else if (sample) begin
            prev_r   <= ramp_wave;
            primed_r <= 1'b1;
        end else begin
            prev_r   <= prev_r;
            primed_r <= primed_r;
        end
    end

    // Unsigned subtraction wraps, so a +max to -max ramp crossing still gives
    // the small positive step.
    assign delta       = ramp_wave - prev_r;
    assign delta_valid = sample & primed_r;

endmodule

// File: rtl/dds_phase_meter.sv
// -----------------------------------------------------------------------------
// dds_phase_meter
// Recovers the tuning word of a DDS from its truncated phase ramp by summing
// 2^G consecutive sample-to-sample increments and scaling the sum back to the
// M-bit tuning-word grid. Consecutive estimates are compared for a lock flag.
// Ports:
//   clk        in  1  system clock, rising edge
//   rst_ac_n   in  1  asynchronous active-low reset
//   ena        in  1  block enable; low freezes all state
//   val_in     in  1  ramp_wave sample valid
//   ramp_wave  in  W  ramp sample (DDS phase top W bits)
//   P_est      out M  recovered tuning word
//   val_out    out 1  one-cycle pulse, P_est updated
//   locked     out 1  consecutive estimates within TOL
//   busy       out 1  a window is in progress
// -----------------------------------------------------------------------------
module dds_phase_meter
    import dds_phase_meter_pkg::*;
#(
    parameter int unsigned M   = DDS_M,
    parameter int unsigned W   = DDS_W,
    parameter int unsigned G   = METER_G,
    parameter int unsigned TOL = 0
) (
    input  logic         clk,
    input  logic         rst_ac_n,
    input  logic         ena,
    input  logic         val_in,
    input  logic [W-1:0] ramp_wave,
    output logic [M-1:0] P_est,
    output logic         val_out,
    output logic         locked,
    output logic         busy
);

    localparam int unsigned AW    = W + G;
    localparam int unsigned SHIFT = M - W - G;
    localparam logic [G-1:0] CNT_ONE  = G'(1);
    localparam logic [G-1:0] CNT_LAST = {G{1'b1}};

    meter_state_t  state_r;
    meter_state_t  state_nxt_s;

    logic [AW-1:0] acc_r;
    logic [G-1:0]  cnt_r;
    logic [M-1:0]  p_est_r;
    logic          val_out_r;
    logic          locked_r;
    logic          busy_r;
    logic          have_est_r;

    logic          sample_s;
    logic [W-1:0]  delta_s;
    logic          delta_valid_s;
    logic [AW-1:0] acc_sum_s;
    logic          window_end_s;
    logic [M-1:0]  p_new_s;
    logic [63:0]   dist_s;
    logic          lock_hit_s;

    assign sample_s = ena & val_in;

    dds_phase_diff #(
        .W (W)
    ) u_diff (
        .clk         (clk),
        .rst_ac_n    (rst_ac_n),
        .sample      (sample_s),
        .ramp_wave   (ramp_wave),
        .delta       (delta_s),
        .delta_valid (delta_valid_s)
    );

    assign acc_sum_s    = acc_r + AW'(delta_s);
    assign window_end_s = delta_valid_s & (cnt_r == CNT_LAST);
    // The W+G-bit sum is in units of 2^(M-W-G) tuning-word LSBs.
    assign p_new_s      = M'(acc_sum_s) << SHIFT;
    assign dist_s       = mod_dist(64'(p_new_s), 64'(p_est_r), M);
    assign lock_hit_s   = have_est_r & (dist_s <= 64'(TOL));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_ac_n) begin
        if (!rst_ac_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state. DONE still accepts a sample, which opens the next window.
    always_comb begin
        state_nxt_s = state_r;
        if (!ena) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sample_s) begin
                        state_nxt_s = ST_PRIME;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PRIME, ST_DONE: begin
                    if (window_end_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_PRIME;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Window accumulator, sample counter and registered result/lock outputs.
    // The result is registered on the edge that takes the last delta, so it is
    // visible together with val_out during the DONE cycle.
    always_ff @(posedge clk or negedge rst_ac_n) begin
        if (!rst_ac_n) begin
            acc_r      <= {AW{1'b0}};
            cnt_r      <= {G{1'b0}};
            p_est_r    <= {M{1'b0}};
            val_out_r  <= 1'b0;
            locked_r   <= 1'b0;
            busy_r     <= 1'b0;
            have_est_r <= 1'b0;
        end else if (ena) begin
            val_out_r <= window_end_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            if (window_end_s) begin
                acc_r      <= {AW{1'b0}};
                cnt_r      <= {G{1'b0}};
                p_est_r    <= p_new_s;
                locked_r   <= lock_hit_s;
                have_est_r <= 1'b1;
            end else if (delta_valid_s) begin
                acc_r <= acc_sum_s;
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
        end else begin
            val_out_r <= val_out_r;
        end
    end

    // A pending pulse is masked while disabled and shows on the next enabled cycle.
    assign val_out = val_out_r & ena;
    assign P_est   = p_est_r;
    assign locked  = locked_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_dds_phase_meter.sv
// -----------------------------------------------------------------------------
// tb_dds_phase_meter
// Drives the meter from a bench-side DDS (unwrapped phase, step P per accepted
// sample) with random valid gaps, enable pauses, tuning switches and resets.
// The reference estimate of a window is the total progress of the phase's top
// bits between the window's first and last sample, modulo 2^M.
// -----------------------------------------------------------------------------
module tb_dds_phase_meter;

    localparam int          M   = 24;
    localparam int          W   = 16;
    localparam int          G   = 8;
    localparam int unsigned TOL = 0;
    localparam int          WIN = 1 << G;

    logic         clk      = 1'b0;
    logic         rst_ac_n = 1'b0;
    logic         ena      = 1'b0;
    logic         val_in   = 1'b0;
    logic [W-1:0] ramp_wave = '0;
    logic [M-1:0] P_est;
    logic         val_out;
    logic         locked;
    logic         busy;

    always #5 clk = ~clk;

    dds_phase_meter #(.M(M), .W(W), .G(G), .TOL(TOL)) dut (
        .clk       (clk),
        .rst_ac_n  (rst_ac_n),
        .ena       (ena),
        .val_in    (val_in),
        .ramp_wave (ramp_wave),
        .P_est     (P_est),
        .val_out   (val_out),
        .locked    (locked),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // stimulus controls
    logic [63:0]  phase_u = '0;
    logic [M-1:0] p_cur   = '0;
    int           val_pct = 100;
    bit           ena_low = 1'b0;

    // reference model state
    bit           m_primed = 1'b0;
    bit           m_pend   = 1'b0;
    bit           m_have   = 1'b0;
    bit           m_lock   = 1'b0;
    int           m_cnt    = 0;
    logic [63:0]  m_start  = '0;
    logic [M-1:0] m_est    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint circ_dist(input logic [M-1:0] a, input logic [M-1:0] b);
        longint span;
        longint d;
        span = longint'(1) << M;
        d = longint'(a) - longint'(b);
        if (d < 0) d = -d;
        if (d > span / 2) d = span - d;
        return d;
    endfunction

    // Estimate of a window = top-bit phase progress, rescaled to the M-bit grid.
    function automatic logic [M-1:0] win_est(input logic [63:0] ph_now, input logic [63:0] top_start);
        logic [63:0] prog;
        prog = (ph_now >> (M - W)) - top_start;
        return M'(prog << (M - W - G));
    endfunction

    // reference model: window bookkeeping on each accepted sample
    always @(posedge clk or negedge rst_ac_n) begin
        if (!rst_ac_n) begin
            m_primed <= 1'b0;
            m_pend   <= 1'b0;
            m_have   <= 1'b0;
            m_lock   <= 1'b0;
            m_cnt    <= 0;
            m_start  <= '0;
            m_est    <= '0;
        end else if (ena) begin
            m_pend <= val_in && m_primed && (m_cnt == WIN - 1);
            if (val_in) begin
                if (!m_primed) begin
                    m_primed <= 1'b1;
                    m_start  <= phase_u >> (M - W);
                    m_cnt    <= 0;
                end else if (m_cnt == WIN - 1) begin
                    m_est   <= win_est(phase_u, m_start);
                    m_lock  <= m_have && (circ_dist(win_est(phase_u, m_start), m_est) <= longint'(TOL));
                    m_have  <= 1'b1;
                    m_cnt   <= 0;
                    m_start <= phase_u >> (M - W);
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        check("val_out", 64'(val_out), 64'(m_pend && ena));
        check("busy",    64'(busy),    64'(m_primed));
        check("P_est",   64'(P_est),   64'(m_est));
        check("locked",  64'(locked),  64'(m_lock));
    end

    // bench DDS: phase advances by P after each accepted sample
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_ac_n && ena && val_in) phase_u = phase_u + 64'(p_cur);
            ena       = !ena_low;
            val_in    = (int'($urandom_range(0, 99)) < val_pct);
            ramp_wave = phase_u[M-1:M-W];
        end
    end

    task automatic wait_vo(input string tag, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            cycles++;
            ok = val_out;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no val_out within 2000 cycles", tag);
        end
    endtask

    task automatic window(input string tag, input logic [M-1:0] exp_p, input bit exp_lock);
        bit ok;
        int cyc;
        wait_vo(tag, ok, cyc);
        if (ok) begin
            check({tag, "_p_est"},  64'(P_est),  64'(exp_p));
            check({tag, "_locked"}, 64'(locked), 64'(exp_lock));
            check({tag, "_model"},  64'(m_est),  64'(exp_p));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ac_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_ac_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int cyc;

        // 1: P=256, reset state, first-window latency
        p_cur   = 24'd256;
        val_pct = 100;
        repeat (3) @(negedge clk);
        check("rst_p_est",  64'(P_est),   64'd0);
        check("rst_val",    64'(val_out), 64'd0);
        check("rst_locked", 64'(locked),  64'd0);
        check("rst_busy",   64'(busy),    64'd0);
        rst_ac_n = 1'b1;
        wait_vo("t1_w1", ok, cyc);
        if (ok) begin
            check("t1_latency", 64'(cyc),    64'd257);
            check("t1_p_est",   64'(P_est),  64'd256);
            check("t1_locked",  64'(locked), 64'd0);
            check("t1_busy",    64'(busy),   64'd1);
        end
        window("t1_w2", 24'd256, 1'b1);

        // 2: P=1000
        do_reset();
        p_cur = 24'd1000;
        window("t2_w1", 24'd1000, 1'b0);
        window("t2_w2", 24'd1000, 1'b1);
        window("t2_w3", 24'd1000, 1'b1);

        // 3: near full scale
        do_reset();
        p_cur = 24'hFFFF00;
        window("t3_w1", 24'hFFFF00, 1'b0);
        window("t3_w2", 24'hFFFF00, 1'b1);

        // 4: random gaps and an enable pause mid-window
        do_reset();
        p_cur   = 24'd1000;
        val_pct = 50;
        window("t4_w1", 24'd1000, 1'b0);
        repeat (60) @(negedge clk);
        ena_low = 1'b1;
        repeat (20) @(negedge clk);
        ena_low = 1'b0;
        window("t4_w2", 24'd1000, 1'b1);

        // 5: tuning switch mid-window
        val_pct = 60;
        repeat (100) @(negedge clk);
        p_cur = 24'd2000;
        wait_vo("t5_w1", ok, cyc);
        if (ok) check("t5_w1_locked", 64'(locked), 64'd0);
        window("t5_w2", 24'd2000, 1'b0);
        window("t5_w3", 24'd2000, 1'b1);

        // 6: asynchronous reset mid-window
        val_pct = 100;
        repeat (50) @(negedge clk);
        @(posedge clk);
        #3;
        rst_ac_n = 1'b0;
        #1;
        check("t6_p_est",  64'(P_est),   64'd0);
        check("t6_locked", 64'(locked),  64'd0);
        check("t6_busy",   64'(busy),    64'd0);
        check("t6_val",    64'(val_out), 64'd0);
        #20;
        rst_ac_n = 1'b1;
        @(negedge clk);
        wait_vo("t6_w1", ok, cyc);
        if (ok) begin
            check("t6_latency", 64'(cyc),   64'd257);
            check("t6_p_est",   64'(P_est), 64'd2000);
        end
        window("t6_w2", 24'd2000, 1'b1);

        // 7: random tuning words (first one P=0) with random gap density
        for (int r = 0; r < 4; r++) begin
            do_reset();
            p_cur   = (r == 0) ? 24'd0 : M'($urandom_range(1, 32'hFF0000));
            val_pct = int'($urandom_range(50, 100));
            window("t7_w1", p_cur, 1'b0);
            window("t7_w2", p_cur, 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
